crc8_check: RTL and testbench
=============================

Name: crc8_check

Overview:
- Receive-side checker for the 40-bit CRC-8 frames built by our transmit path: 32-bit payload followed by an 8-bit CRC.
- CRC definition: polynomial x^8+x^5+x^4+1 (POLY=8'h31), init 0, MSB-first, no reflection, no final XOR.
- Frames arrive one byte at a time on a valid/ready stream. The block recomputes the CRC over all 5 bytes and presents the 32-bit payload plus a pass/fail flag on a valid/ready output.
- Sits between the byte link deserializer and payload consumers.

Parameters:
- POLY, 8'h31, CRC-8 generator polynomial without the x^8 term.
- CNT_W, 16, width of the optional error/statistics counters.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_data  input  8  frame byte. Order: payload[31:24], [23:16], [15:8], [7:0], then CRC.
- in_sof  input  1  marks the first byte of a frame.
- in_valid  input  1  in_data/in_sof valid.
- in_ready  output  1  block accepts the byte this cycle.
- out_data  output  32  received payload.
- out_crc_ok  output  1  1 = CRC matched.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- sync_err  output  1  one-cycle pulse on a framing error.
- err_cnt  output  CNT_W  CRC-fail count (optional feature).
- frm_cnt  output  CNT_W  total completed frames (optional feature).

Behaviour:
- Reset (rst high at a clk edge): state=RECV, byte count=0, running CRC=0, out_data=0, out_crc_ok=0, out_valid=0, sync_err=0, err_cnt=0, frm_cnt=0.
- rst has priority over every other event, including a partial frame or a held result; that frame is dropped.
- States:
  - RECV: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- A byte is accepted only when in_valid=1 and in_ready=1.
- RECV, accepted byte with in_sof=1: count=1, crc=step(8'h00, in_data), payload[31:24]=in_data.
  - If the previous count was 1..4, the partial frame is discarded and sync_err pulses the next cycle.
- RECV, accepted byte with in_sof=0 and count=0: byte discarded, count stays 0, sync_err pulses the next cycle.
- RECV, accepted byte with in_sof=0 and count=1..3: crc=step(crc, in_data), byte stored in the next payload slot, count incremented.
- RECV, accepted byte with in_sof=0 and count=4 (the CRC byte):
  - out_crc_ok = (step(crc, in_data) == 8'h00); equivalently, the computed CRC of the 4 payload bytes equals in_data.
  - out_data = payload; next state HOLD; count=0.
  - out_valid rises on the cycle after the 5th byte is accepted.
  - Minimum spacing between frames is 6 cycles.
- step(c, b): for 8 iterations, MSB of b first, fb = c[7]^bit; c = {c[6:0],1'b0} ^ (fb ? POLY : 0). All 8 iterations complete within one cycle, combinationally.
- HOLD:
  - out_data and out_crc_ok stay stable until out_ready=1.
  - out_valid && out_ready at an edge: next state RECV, out_valid=0 from the next cycle.
  - in_ready=0 throughout, so no byte is lost while a result is held.
- After a valid output handshake, out_data and out_crc_ok keep their last values.
- sync_err is never asserted in HOLD.

Optional Feature:
- Macro CRC8_CHK_CNT_EN.
- Defined:
  - frm_cnt increments on every transition into HOLD.
  - err_cnt increments on every transition into HOLD with out_crc_ok=0.
  - Both counters saturate at all-ones and do not wrap.
  - Both are cleared only by rst.
- Not defined: err_cnt and frm_cnt are tied to 0 and no counter flops are synthesized. Port list is unchanged.

Test Plan:
- Good frame: bytes 00,00,00,01,31 (sof on the first) with out_ready=1 -> out_valid one cycle after the last byte, out_data=32'h00000001, out_crc_ok=1.
- Bad CRC: bytes 00,00,00,80,7B -> out_crc_ok=0, out_data=32'h00000080. With the macro, err_cnt=1, frm_cnt=1. Repeat with 7A -> out_crc_ok=1.
- Backpressure: good frame with out_ready=0 for 10 cycles -> out_valid held 10+ cycles, in_ready=0, outputs stable. A byte offered meanwhile is not consumed and is accepted only after the out_ready handshake.
- Resync: sof 12,34 then sof 00,00,00,01,31 -> sync_err pulses once, then a single result 32'h00000001 with ok=1. A stray byte with sof=0 in idle -> sync_err pulse, no output.
- Reset mid-frame: rst high after 3 bytes, then full good frame -> exactly one output, correct and ok. rst during HOLD -> out_valid=0 the next cycle, counters cleared.
- Counter saturation (macro, CNT_W=4): 17 bad frames -> err_cnt=4'hF and frm_cnt=4'hF, holding at F. Without the macro, both stay 0.

Source files
------------

// File: rtl/crc8_check.sv
// Receive-side CRC-8 checker for 40-bit frames (4 payload bytes + CRC byte).
// Optional saturating frame/error counters are enabled by defining CRC8_CHK_CNT_EN.
module crc8_check #(
  parameter logic [7:0] POLY  = 8'h31,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_sof,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic             out_crc_ok,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sync_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] frm_cnt
);

  typedef enum logic {RECV, HOLD} state_t;

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [7:0]  crc, crc_nx;
  logic [31:0] payload, payload_nx;
  logic [31:0] out_data_nx;
  logic        out_crc_ok_nx;
  logic        sync_err_nx;
  logic        accept;
  logic [7:0]  crc_byte;

  // One full byte of the MSB-first CRC shift register, unrolled into one cycle.
  function automatic logic [7:0] step(input logic [7:0] c_in, input logic [7:0] b);
    logic [7:0] c;
    logic       fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ b[i];
      c  = {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
    end
    return c;
  endfunction

  assign accept   = in_valid && in_ready;
  assign crc_byte = step(crc, in_data);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nx      = state;
    cnt_nx        = cnt;
    crc_nx        = crc;
    payload_nx    = payload;
    out_data_nx   = out_data;
    out_crc_ok_nx = out_crc_ok;
    sync_err_nx   = 1'b0;
    in_ready      = (state == RECV);
    out_valid     = (state == HOLD);
    case (state)
      RECV: begin
        if (accept) begin
          if (in_sof) begin
            sync_err_nx = (cnt != 3'd0);
            cnt_nx      = 3'd1;
            crc_nx      = step(8'h00, in_data);
            payload_nx  = {in_data, 24'h000000};
          end else if (cnt == 3'd0) begin
            sync_err_nx = 1'b1;
          end else if (cnt == 3'd4) begin
            out_crc_ok_nx = (crc_byte == 8'h00);
            out_data_nx   = payload;
            state_nx      = HOLD;
            cnt_nx        = 3'd0;
          end else begin
            crc_nx = crc_byte;
            cnt_nx = cnt + 3'd1;
            case (cnt)
              3'd1:    payload_nx[23:16] = in_data;
              3'd2:    payload_nx[15:8]  = in_data;
              default: payload_nx[7:0]   = in_data;
            endcase
          end
        end
      end
      HOLD: begin
        if (out_ready) state_nx = RECV;
      end
      default: state_nx = RECV;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state      <= RECV;
      cnt        <= 3'd0;
      crc        <= 8'h00;
      payload    <= 32'h0;
      out_data   <= 32'h0;
      out_crc_ok <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      crc        <= crc_nx;
      payload    <= payload_nx;
      out_data   <= out_data_nx;
      out_crc_ok <= out_crc_ok_nx;
      sync_err   <= sync_err_nx;
    end
  end

`ifdef CRC8_CHK_CNT_EN
  logic enter_hold;
  assign enter_hold = (state == RECV) && (state_nx == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      frm_cnt <= '0;
      err_cnt <= '0;
    end else if (enter_hold) begin
      if (frm_cnt != '1) frm_cnt <= frm_cnt + 1'b1;
      if (!out_crc_ok_nx && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  assign frm_cnt = '0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_crc8_check.sv
// Self-checking bench for crc8_check: directed framing cases plus random payloads
// checked against a polynomial-division CRC model; counters expected per CRC8_CHK_CNT_EN.
module tb_crc8_check;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       in_data;
  logic             in_sof;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      out_data;
  logic             out_crc_ok;
  logic             out_valid;
  logic             out_ready;
  logic             sync_err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] frm_cnt;

  int total  = 0;
  int passed = 0;
  int exp_frm = 0;
  int exp_err = 0;

  crc8_check #(.POLY(8'h31), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sof(in_sof), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_crc_ok(out_crc_ok),
    .out_valid(out_valid), .out_ready(out_ready), .sync_err(sync_err),
    .err_cnt(err_cnt), .frm_cnt(frm_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // CRC as the remainder of {payload, 8'h00} divided by x^8+x^5+x^4+1.
  function automatic logic [7:0] crc_ref(input logic [31:0] p);
    logic [39:0] r;
    r = {p, 8'h00};
    for (int i = 39; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h131;
    return r[7:0];
  endfunction

  task automatic model_frame(input logic ok);
`ifdef CRC8_CHK_CNT_EN
    if (exp_frm < 15) exp_frm++;
    if (!ok && exp_err < 15) exp_err++;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_frm = 0;
    exp_err = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic sof, input logic exp_sync);
    int n = 0;
    @(negedge clk);
    in_data  = b;
    in_sof   = sof;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    check("sync_err", sync_err, exp_sync);
  endtask

  task automatic check_result(input string tag, input logic [31:0] p, input logic ok);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_data"}, out_data, p);
    check({tag, "_ok"}, out_crc_ok, ok);
    check({tag, "_frm_cnt"}, frm_cnt, exp_frm[CNT_W-1:0]);
    check({tag, "_err_cnt"}, err_cnt, exp_err[CNT_W-1:0]);
  endtask

  task automatic send_frame(input string tag, input logic [31:0] p, input logic [7:0] c);
    logic ok;
    ok = (c == crc_ref(p));
    send_byte(p[31:24], 1'b1, 1'b0);
    send_byte(p[23:16], 1'b0, 1'b0);
    send_byte(p[15:8],  1'b0, 1'b0);
    send_byte(p[7:0],   1'b0, 1'b0);
    send_byte(c,        1'b0, 1'b0);
    model_frame(ok);
    check_result(tag, p, ok);
  endtask

  task automatic handshake(input logic [31:0] p, input logic ok);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("hs_valid_low", out_valid, 1'b0);
    check("hs_in_ready", in_ready, 1'b1);
    check("hs_data_kept", out_data, p);
    check("hs_ok_kept", out_crc_ok, ok);
  endtask

  initial begin
    logic [31:0] p;
    logic [7:0]  c;
    rst = 1'b0; in_data = 8'h00; in_sof = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    // Reset state
    do_reset();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_ok", out_crc_ok, 1'b0);
    check("rst_sync_err", sync_err, 1'b0);
    check("rst_err_cnt", err_cnt, 4'h0);
    check("rst_frm_cnt", frm_cnt, 4'h0);

    // Known vectors: good frame, bad CRC, corrected CRC
    send_frame("good", 32'h00000001, 8'h31);
    handshake(32'h00000001, 1'b1);
    send_frame("bad", 32'h00000080, 8'h7B);
    handshake(32'h00000080, 1'b0);
    send_frame("fixed", 32'h00000080, 8'h7A);
    handshake(32'h00000080, 1'b1);

    // Random payloads, about half with a corrupted CRC byte
    for (int k = 0; k < 8; k++) begin
      p = $urandom;
      c = crc_ref(p);
      if ($urandom_range(0, 1) == 1) c = c ^ 8'($urandom_range(1, 255));
      send_frame("rand", p, c);
      handshake(p, c == crc_ref(p));
    end

    // Backpressure: result held, a waiting byte is only taken after the handshake
    send_frame("bp", 32'h00000001, 8'h31);
    @(negedge clk);
    in_data = 8'hAA; in_sof = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check("bp_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_data", out_data, 32'h00000001);
      check("bp_ok", out_crc_ok, 1'b1);
    end
    handshake(32'h00000001, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0; in_sof = 1'b0;
    check("bp_sync_err", sync_err, 1'b0);
    p = 32'hAA123456;
    send_byte(p[23:16], 1'b0, 1'b0);
    send_byte(p[15:8],  1'b0, 1'b0);
    send_byte(p[7:0],   1'b0, 1'b0);
    send_byte(crc_ref(p), 1'b0, 1'b0);
    model_frame(1'b1);
    check_result("bp_next", p, 1'b1);
    handshake(p, 1'b1);

    // Resync: a truncated frame followed by a fresh start-of-frame
    send_byte(8'h12, 1'b1, 1'b0);
    send_byte(8'h34, 1'b0, 1'b0);
    send_byte(8'h00, 1'b1, 1'b1);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h31, 1'b0, 1'b0);
    model_frame(1'b1);
    check_result("resync", 32'h00000001, 1'b1);
    handshake(32'h00000001, 1'b1);

    // Stray byte while idle
    send_byte(8'h55, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("stray_pulse_end", sync_err, 1'b0);
    check("stray_no_out", out_valid, 1'b0);

    // Reset mid-frame drops the partial frame
    send_byte(8'hDE, 1'b1, 1'b0);
    send_byte(8'hAD, 1'b0, 1'b0);
    send_byte(8'hBE, 1'b0, 1'b0);
    do_reset();
    check("midrst_valid", out_valid, 1'b0);
    send_frame("after_rst", 32'h00000001, 8'h31);
    handshake(32'h00000001, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 check("single_output", out_valid, 1'b0);
    end

    // Reset while a result is held
    send_frame("pre_hold_rst", 32'h00000080, 8'h7B);
    do_reset();
    check("holdrst_valid", out_valid, 1'b0);
    check("holdrst_in_ready", in_ready, 1'b1);
    check("holdrst_frm_cnt", frm_cnt, 4'h0);
    check("holdrst_err_cnt", err_cnt, 4'h0);

    // Counter saturation: 17 bad frames
    for (int k = 0; k < 17; k++) begin
      p = $urandom;
      send_frame("sat", p, crc_ref(p) ^ 8'h01);
      handshake(p, 1'b0);
    end
`ifdef CRC8_CHK_CNT_EN
    check("sat_frm_final", frm_cnt, 4'hF);
    check("sat_err_final", err_cnt, 4'hF);
`else
    check("nocnt_frm_final", frm_cnt, 4'h0);
    check("nocnt_err_final", err_cnt, 4'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
